// File: rtl/spi_mem_arbiter_if.sv
// Request and SPI-master bundles for the shared SPI memory arbiter.
// mem_req_if: requester <-> arbiter; spi_xfer_if: arbiter <-> SPI master.
interface mem_req_if #(
    parameter int LEN_W = 8
);
    logic             valid;
    logic [7:0]       cmd;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             ready;
    logic             done;

    modport master (
        output valid, cmd, addr, len,
        input  ready, done
    );

    modport slave (
        input  valid, cmd, addr, len,
        output ready, done
    );
endinterface

interface spi_xfer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [7:0]       cmd;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;

    modport master (
        output start, cmd, addr, len,
        input  busy, done
    );

    modport slave (
        input  start, cmd, addr, len,
        output busy, done
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory master between two requesters.
// Also sequences memory power: power-up delay, inter-transaction gap, idle power-down.
module spi_mem_arbiter #(
    parameter int LEN_W        = 8,
    parameter int PWRUP_CYCLES = 1000,
    parameter int GAP_CYCLES   = 4,
    parameter int IDLE_CYCLES  = 65535
) (
    input  logic       CLKA,
    input  logic       rst_n,
    mem_req_if.slave   req0,
    mem_req_if.slave   req1,
    spi_xfer_if.master spi,
    output logic       mem_vcc,
    output logic       mem_ready,
    output logic       owner
);

    localparam int MAX_A = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int MAX_B = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_B) + 1;

    localparam logic [CNT_W-1:0] PWRUP_L = CNT_W'(PWRUP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_L   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_L  = CNT_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWRUP,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rr_ptr;

    logic             any_valid;
    logic             win;
    logic [7:0]       cmd_sel;
    logic [23:0]      addr_sel;
    logic [LEN_W-1:0] len_sel;

    // Pick the winner: lone requester wins, a tie goes to the rr pointer.
    always_comb begin
        any_valid = req0.valid | req1.valid;
        win       = 1'b0;
        if (req0.valid && req1.valid) begin
            win = rr_ptr;
        end else begin
            win = req1.valid;
        end
        cmd_sel  = win ? req1.cmd  : req0.cmd;
        addr_sel = win ? req1.addr : req0.addr;
        len_sel  = win ? req1.len  : req0.len;
        cnt_nxt  = cnt + 1'b1;
    end

    // Power/transaction sequencer with registered outputs.
    always_ff @(posedge CLKA) begin
        if (!rst_n) begin
            state      <= S_OFF;
            cnt        <= '0;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            mem_vcc    <= 1'b0;
            mem_ready  <= 1'b0;
            req0.ready <= 1'b0;
            req1.ready <= 1'b0;
            req0.done  <= 1'b0;
            req1.done  <= 1'b0;
            spi.start  <= 1'b0;
            spi.cmd    <= '0;
            spi.addr   <= '0;
            spi.len    <= '0;
        end else begin
            req0.ready <= 1'b0;
            req1.ready <= 1'b0;
            req0.done  <= 1'b0;
            req1.done  <= 1'b0;
            spi.start  <= 1'b0;
            unique case (state)
                S_OFF: begin
                    if (any_valid) begin
                        state   <= S_PWRUP;
                        mem_vcc <= 1'b1;
                        cnt     <= '0;
                    end
                end
                S_PWRUP: begin
                    if (cnt_nxt >= PWRUP_L) begin
                        state     <= S_IDLE;
                        mem_ready <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_IDLE: begin
                    if (any_valid) begin
                        state      <= S_ISSUE;
                        owner      <= win;
                        rr_ptr     <= ~win;
                        req0.ready <= ~win;
                        req1.ready <= win;
                        spi.cmd    <= cmd_sel;
                        spi.addr   <= addr_sel;
                        spi.len    <= len_sel;
                        cnt        <= '0;
                    end else if (IDLE_CYCLES != 0) begin
                        if (cnt_nxt == IDLE_L) begin
                            state     <= S_OFF;
                            mem_vcc   <= 1'b0;
                            mem_ready <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!spi.busy) begin
                        spi.start <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (spi.done) begin
                        req0.done <= ~owner;
                        req1.done <= owner;
                        state     <= S_GAP;
                        cnt       <= '0;
                    end
                end
                S_GAP: begin
                    if (cnt_nxt >= GAP_L) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed self-checking bench for spi_mem_arbiter.
// Small timing parameters: PWRUP=12, GAP=4, IDLE=20.
module tb_spi_mem_arbiter;

    localparam int P = 12;
    localparam int G = 4;
    localparam int I = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_vcc;
    logic mem_ready;
    logic owner;

    int checks   = 0;
    int failures = 0;
    bit hold0    = 1'b0;
    bit hold1    = 1'b0;

    mem_req_if  #(.LEN_W(8)) r0_if ();
    mem_req_if  #(.LEN_W(8)) r1_if ();
    spi_xfer_if #(.LEN_W(8)) s_if ();

    spi_mem_arbiter #(
        .LEN_W       (8),
        .PWRUP_CYCLES(P),
        .GAP_CYCLES  (G),
        .IDLE_CYCLES (I)
    ) dut (
        .CLKA     (clk),
        .rst_n    (rst_n),
        .req0     (r0_if),
        .req1     (r1_if),
        .spi      (s_if),
        .mem_vcc  (mem_vcc),
        .mem_ready(mem_ready),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesters drop valid once accepted unless told to keep it up.
    task automatic tick;
        @(posedge clk);
        #1;
        if (!hold0 && r0_if.ready) r0_if.valid = 1'b0;
        if (!hold1 && r1_if.ready) r1_if.valid = 1'b0;
    endtask

    function automatic logic sigv(input int w);
        case (w)
            0:       return s_if.start;
            1:       return r0_if.ready;
            2:       return r1_if.ready;
            default: return r0_if.ready | r1_if.ready;
        endcase
    endfunction

    task automatic wait_ev(input string tag, input int w, input int budget,
                           output int n);
        n = 0;
        while (!sigv(w) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sigv(w)}, 32'd1);
    endtask

    task automatic spi_finish;
        spi_done_set(1'b1);
        tick();
        spi_done_set(1'b0);
    endtask

    task automatic spi_done_set(input logic v);
        s_if.done = v;
    endtask

    initial begin
        int n;
        int n1;
        int n2;
        int starts;
        logic g;

        rst_n       = 1'b0;
        r0_if.valid = 1'b0;
        r0_if.cmd   = '0;
        r0_if.addr  = '0;
        r0_if.len   = '0;
        r1_if.valid = 1'b0;
        r1_if.cmd   = '0;
        r1_if.addr  = '0;
        r1_if.len   = '0;
        s_if.busy   = 1'b0;
        s_if.done   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_vcc", mem_vcc, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_start", s_if.start, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdy0", r0_if.ready, 0);
        rst_n = 1'b1;
        tick();
        chk("off_vcc", mem_vcc, 0);

        // First request from port 0: power-up then issue
        r0_if.cmd   = 8'h03;
        r0_if.addr  = 24'h000100;
        r0_if.len   = 8'd4;
        r0_if.valid = 1'b1;
        tick();
        chk("pwr_vcc", mem_vcc, 1);
        chk("pwr_mready", mem_ready, 0);
        wait_ev("to_start0", 0, 100, n);
        chk("pwr_lat", n, P + 2);
        chk("cmd0", s_if.cmd, 32'h03);
        chk("addr0", s_if.addr, 32'h000100);
        chk("len0", s_if.len, 4);
        chk("mready_on", mem_ready, 1);
        chk("owner0", owner, 0);
        tick();
        chk("start_pulse", s_if.start, 0);
        tick();
        spi_finish();
        chk("done0", r0_if.done, 1);
        chk("done0_n1", r1_if.done, 0);
        tick();
        chk("done0_end", r0_if.done, 0);

        // Port 1 with SPI master busy for 5 cycles in ISSUE
        s_if.busy   = 1'b1;
        r1_if.cmd   = 8'h0B;
        r1_if.addr  = 24'h123456;
        r1_if.len   = 8'd0;
        r1_if.valid = 1'b1;
        wait_ev("to_ready1", 2, 50, n);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (s_if.start) starts++;
        end
        chk("busy_hold", starts, 0);
        s_if.busy = 1'b0;
        tick();
        chk("busy_start", s_if.start, 1);
        chk("cmd1", s_if.cmd, 32'h0B);
        chk("addr1", s_if.addr, 32'h123456);
        starts = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (s_if.start) starts++;
        end
        chk("busy_single", starts, 0);
        spi_finish();
        chk("done1", r1_if.done, 1);
        chk("done1_n0", r0_if.done, 0);
        chk("owner1", owner, 1);

        // Both held continuously: strict alternation starting at port 0
        hold0       = 1'b1;
        hold1       = 1'b1;
        r0_if.cmd   = 8'h05;
        r1_if.cmd   = 8'h06;
        r0_if.valid = 1'b1;
        r1_if.valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ev("to_grant", 3, 50, n1);
            g = r1_if.ready;
            chk("grant_seq", {31'd0, g}, k % 2);
            chk("grant_one", {31'd0, r0_if.ready & r1_if.ready}, 0);
            wait_ev("to_start_alt", 0, 20, n2);
            chk("gap_lat", n1 + n2, G + 2);
            chk("alt_owner", owner, k % 2);
            chk("alt_cmd", s_if.cmd, (k % 2) ? 32'h06 : 32'h05);
            tick();
            spi_finish();
            chk("alt_done", g ? r1_if.done : r0_if.done, 1);
        end
        hold0       = 1'b0;
        hold1       = 1'b0;
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;

        // GAP runs out, then a stray spi_done in IDLE
        for (int k = 0; k < G; k++) tick();
        spi_finish();
        chk("spur_done0", r0_if.done, 0);
        chk("spur_done1", r1_if.done, 0);
        chk("spur_start", s_if.start, 0);
        chk("spur_vcc", mem_vcc, 1);

        // Idle power-down after I idle cycles
        for (int k = 0; k < I - 2; k++) tick();
        chk("idle_vcc_hi", mem_vcc, 1);
        chk("idle_mrdy_hi", mem_ready, 1);
        tick();
        chk("idle_vcc_lo", mem_vcc, 0);
        chk("idle_mrdy_lo", mem_ready, 0);

        // Re-power via port 1
        r1_if.cmd   = 8'h9F;
        r1_if.addr  = 24'h000000;
        r1_if.len   = 8'd3;
        r1_if.valid = 1'b1;
        tick();
        chk("repwr_vcc", mem_vcc, 1);
        chk("repwr_mrdy", mem_ready, 0);
        wait_ev("to_start_re", 0, 100, n);
        chk("repwr_lat", n, P + 2);
        chk("repwr_cmd", s_if.cmd, 32'h9F);
        chk("repwr_len", s_if.len, 3);
        chk("repwr_owner", owner, 1);

        // Reset while waiting for spi_done
        tick();
        rst_n     = 1'b0;
        s_if.done = 1'b1;
        tick();
        chk("mrst_done1", r1_if.done, 0);
        chk("mrst_vcc", mem_vcc, 0);
        chk("mrst_mrdy", mem_ready, 0);
        chk("mrst_owner", owner, 0);
        chk("mrst_cmd", s_if.cmd, 0);
        rst_n     = 1'b1;
        s_if.done = 1'b0;
        tick();
        chk("mrst_done1b", r1_if.done, 0);
        chk("mrst_vcc_off", mem_vcc, 0);

        // Normal service after reset
        r0_if.cmd   = 8'h02;
        r0_if.addr  = 24'hABCDEF;
        r0_if.len   = 8'hFF;
        r0_if.valid = 1'b1;
        tick();
        chk("post_vcc", mem_vcc, 1);
        wait_ev("to_start_post", 0, 100, n);
        chk("post_lat", n, P + 2);
        chk("post_addr", s_if.addr, 32'hABCDEF);
        chk("post_len", s_if.len, 32'hFF);
        tick();
        spi_finish();
        chk("post_done0", r0_if.done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
